// File: rtl/serial_operand_piso.sv
// Parallel-in/serial-out operand feeder for a bit-serial adder.
// Captures A, B and carry-in on start, then emits one LSB-first bit pair per clock with framing strobes.
module serial_operand_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             a_bit,
    output logic             b_bit,
    output logic             carry_init,
    output logic             first_bit,
    output logic             last_bit,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic             carry_init_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            carry_init_q <= 1'b0;
            count_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sr_q       <= a_in;
                        b_sr_q       <= b_in;
                        carry_init_q <= cin_in;
                        count_q      <= '0;
                        state_q      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Zero fill keeps the registers clean once the operation ends.
                    a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic in_shift;
    assign in_shift = (state_q == S_SHIFT);

    // Bits are gated so the adder never sees stale data outside the window.
    assign a_bit      = in_shift & a_sr_q[0];
    assign b_bit      = in_shift & b_sr_q[0];
    assign bit_valid  = in_shift;
    assign first_bit  = in_shift & (count_q == '0);
    assign last_bit   = in_shift & (count_q == LAST);
    assign carry_init = carry_init_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_operand_piso.sv
// Randomized bench for serial_operand_piso: a per-operation schedule model predicts every
// cycle's outputs, and a bit-serial adder rebuilds the sum from the observed stream.
module tb_serial_operand_piso;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         a_bit, b_bit, carry_init, first_bit, last_bit, bit_valid, busy, done;

    serial_operand_piso #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .cin_in     (cin_in),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .carry_init (carry_init),
        .first_bit  (first_bit),
        .last_bit   (last_bit),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One entry per non-idle cycle of an operation: WIDTH bit cycles then the done cycle.
    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
        logic valid;
        logic dn;
    } ent_t;

    ent_t         sched[$];
    logic [8:0]   sums[$];
    logic         cin_exp = 1'b0;

    logic [W-1:0] sum_obs;
    logic         c_obs;
    int           idx_obs;

    task automatic model_reset();
        sched.delete();
        sums.delete();
        cin_exp = 1'b0;
    endtask

    task automatic model_edge();
        ent_t e;
        if (sched.size() != 0) begin
            void'(sched.pop_front());
        end else if (start) begin
            for (int i = 0; i < W; i++) begin
                e.a     = a_in[i];
                e.b     = b_in[i];
                e.first = (i == 0);
                e.last  = (i == W - 1);
                e.valid = 1'b1;
                e.dn    = 1'b0;
                sched.push_back(e);
            end
            e = '0;
            e.dn = 1'b1;
            sched.push_back(e);
            cin_exp = cin_in;
            sums.push_back({1'b0, a_in} + {1'b0, b_in} + 9'(cin_in));
        end
    endtask

    task automatic check_outputs();
        logic [7:0] obs, exp;
        ent_t e;
        obs = {a_bit, b_bit, carry_init, first_bit, last_bit, bit_valid, busy, done};
        if (sched.size() == 0) begin
            exp = {2'b00, cin_exp, 5'b00000};
        end else begin
            e   = sched[0];
            exp = {e.a, e.b, cin_exp, e.first, e.last, e.valid, 1'b1, e.dn};
        end
        check_eq("outs{a,b,cin,first,last,valid,busy,done}", 32'(obs), 32'(exp));

        // Downstream adder + SIPO built from what the DUT actually emitted.
        if (bit_valid === 1'b1) begin
            if (first_bit === 1'b1) begin
                c_obs   = carry_init;
                idx_obs = 0;
                sum_obs = '0;
            end
            if (idx_obs < W) sum_obs[idx_obs] = a_bit ^ b_bit ^ c_obs;
            c_obs = (a_bit & b_bit) | (c_obs & (a_bit ^ b_bit));
            idx_obs++;
        end
        if (done === 1'b1) begin
            if (sums.size() != 0) begin
                check_eq("serial_sum", 32'({c_obs, sum_obs}), 32'(sums.pop_front()));
            end else begin
                check_eq("unexpected_done", 32'(done), 32'(0));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
    endtask

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        a_in   = a;
        b_in   = b;
        cin_in = c;
    endtask

    initial begin
        c_obs   = 1'b0;
        idx_obs = 0;
        sum_obs = '0;

        // Reset with start asserted and random operands.
        rst_n = 1'b0;
        start = 1'b1;
        set_ops(W'($urandom), W'($urandom), 1'b1);
        #1;
        check_outputs();
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) tick();

        // Basic A5/3C, expect sum E1.
        set_ops(8'hA5, 8'h3C, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();

        // Carry/overflow FF+01+1.
        set_ops(8'hFF, 8'h01, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();

        // Start re-pulsed during bit 3 with new operands must be ignored.
        set_ops(8'h96, 8'h4B, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_ops(8'h00, 8'h00, 1'b1);
        repeat (3) tick();
        start = 1'b1;
        set_ops(8'h7E, 8'hE7, 1'b1);
        tick();
        start = 1'b0;
        repeat (9) tick();

        // Back-to-back with start held high.
        set_ops(8'h0F, 8'hF0, 1'b0);
        start = 1'b1;
        tick();
        set_ops(8'h55, 8'hAA, 1'b1);
        repeat (10) tick();
        start = 1'b0;
        repeat (10) tick();

        // Mid-operation reset during bit 5, then a clean operation.
        set_ops(8'hC3, 8'h5A, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        apply_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        set_ops(8'h3D, 8'h2E, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            set_ops(W'($urandom), W'($urandom), 1'($urandom));
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                apply_reset();
            end
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
